// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259 interrupt-acknowledge sequencer.
// Optional rotating priority is enabled with the PIC_ROTATE_EN macro.
package pic_pkg;

    localparam int NUM_IRQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INT_PEND  = 2'd1,
        WAIT_ACK2 = 2'd2
    } state_t;

    function automatic logic [7:0] rotl8(input logic [7:0] v,
                                         input logic [2:0] n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Finds the highest-priority set bit of req, with priority starting at base.
// Index base is highest, wrapping modulo 8.
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [7:0] req,
    input  logic [2:0] base,
    output logic       found,
    output logic [2:0] idx
);

    logic [7:0] rot;
    logic [2:0] rel;

    assign rot = rotl8(req, 3'(-base));

    // Lowest set bit of the rotated request is the winner
    always_comb begin
        rel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) begin
                rel = 3'(i);
            end
        end
    end

    assign found = |req;
    assign idx   = rel + base;

endmodule

// File: rtl/pic_inta_sequencer.sv
// 8259 INTA sequencer: nested priority, INT, two-strobe ack, ISR and EOI.
// Define PIC_ROTATE_EN for rotating priority with rotate_on_eoi.
module pic_inta_sequencer
    import pic_pkg::*;
#(
    parameter logic [2:0] SPURIOUS_IDX = 3'd7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irr,
    input  logic [7:0] imr,
    input  logic       inta1_stb,
    input  logic       inta2_stb,
    input  logic       aeoi_mode,
    input  logic       eoi_stb,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic [4:0] vector_base,
`ifdef PIC_ROTATE_EN
    input  logic       rotate_on_eoi,
`endif
    output logic       int_out,
    output logic [7:0] isr,
    output logic [7:0] irr_clr,
    output logic [7:0] vector_out,
    output logic       vector_valid,
    output logic [2:0] last_serviced_idx
);

    state_t     state_q, state_d;
    logic       int_q, int_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] irr_clr_q, irr_clr_d;
    logic [7:0] vec_q, vec_d;
    logic       vv_q, vv_d;
    logic [2:0] last_q, last_d;
    logic [2:0] cur_q, cur_d;
    logic       spur_q, spur_d;
    logic [2:0] base;

`ifdef PIC_ROTATE_EN
    logic [2:0] base_q, base_d;
    assign base = base_q;
`else
    assign base = 3'd0;
`endif

    logic       cand_found, top_found, cand_ok;
    logic [2:0] cand_idx, top_idx;
    logic [7:0] clr_m, set_m;

    pic_priority_resolver u_cand (
        .req   (irr & ~imr),
        .base  (base),
        .found (cand_found),
        .idx   (cand_idx)
    );

    pic_priority_resolver u_top (
        .req   (isr_q),
        .base  (base),
        .found (top_found),
        .idx   (top_idx)
    );

    // Candidate must strictly outrank the highest in-service level
    always_comb begin
        cand_ok = cand_found &&
                  (!top_found ||
                   (3'(cand_idx - base) < 3'(top_idx - base)));
    end

    // Next state, ack sequencing, EOI/AEOI clears and ISR sets
    always_comb begin
        state_d   = state_q;
        int_d     = int_q;
        irr_clr_d = 8'h00;
        vec_d     = vec_q;
        vv_d      = 1'b0;
        last_d    = last_q;
        cur_d     = cur_q;
        spur_d    = spur_q;
        clr_m     = 8'h00;
        set_m     = 8'h00;
`ifdef PIC_ROTATE_EN
        base_d    = base_q;
`endif
        unique case (state_q)
            IDLE: begin
                int_d = 1'b0;
                if (cand_ok) begin
                    state_d = INT_PEND;
                    int_d   = 1'b1;
                end
            end
            INT_PEND: begin
                if (inta1_stb) begin
                    int_d   = 1'b0;
                    state_d = WAIT_ACK2;
                    if (cand_ok) begin
                        cur_d     = cand_idx;
                        spur_d    = 1'b0;
                        set_m     = 8'(1) << cand_idx;
                        irr_clr_d = 8'(1) << cand_idx;
                    end else begin
                        cur_d  = SPURIOUS_IDX;
                        spur_d = 1'b1;
                    end
                end
            end
            WAIT_ACK2: begin
                int_d = 1'b0;
                if (inta2_stb) begin
                    vec_d   = {vector_base, cur_q};
                    vv_d    = 1'b1;
                    state_d = IDLE;
                    if (aeoi_mode && !spur_q) begin
                        clr_m  = clr_m | (8'(1) << cur_q);
                        last_d = cur_q;
`ifdef PIC_ROTATE_EN
                        if (rotate_on_eoi) base_d = cur_q + 3'd1;
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
                int_d   = 1'b0;
            end
        endcase
        if (eoi_stb) begin
            if (eoi_specific) begin
                if (isr_q[eoi_level]) begin
                    clr_m  = clr_m | (8'(1) << eoi_level);
                    last_d = eoi_level;
                end
            end else if (top_found) begin
                clr_m  = clr_m | (8'(1) << top_idx);
                last_d = top_idx;
`ifdef PIC_ROTATE_EN
                if (rotate_on_eoi) base_d = top_idx + 3'd1;
`endif
            end
        end
        isr_d = (isr_q & ~clr_m) | set_m;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            int_q     <= 1'b0;
            isr_q     <= 8'h00;
            irr_clr_q <= 8'h00;
            vec_q     <= 8'h00;
            vv_q      <= 1'b0;
            last_q    <= 3'd0;
            cur_q     <= 3'd0;
            spur_q    <= 1'b0;
`ifdef PIC_ROTATE_EN
            base_q    <= 3'd0;
`endif
        end else begin
            state_q   <= state_d;
            int_q     <= int_d;
            isr_q     <= isr_d;
            irr_clr_q <= irr_clr_d;
            vec_q     <= vec_d;
            vv_q      <= vv_d;
            last_q    <= last_d;
            cur_q     <= cur_d;
            spur_q    <= spur_d;
`ifdef PIC_ROTATE_EN
            base_q    <= base_d;
`endif
        end
    end

    assign int_out           = int_q;
    assign isr               = isr_q;
    assign irr_clr           = irr_clr_q;
    assign vector_out        = vec_q;
    assign vector_valid      = vv_q;
    assign last_serviced_idx = last_q;

endmodule
